wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue_pkg.sv | 14 +
 rtl/wb_queue_if.sv | 39 +++
 rtl/wb_fwd_sel.sv | 39 +++
 rtl/wb_queue.sv | 125 ++++++++++++
 tb/tb_wb_queue.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_queue_pkg.sv
// Shared CPU parameters for the register-file write path.
// Holds the write-back queue defaults and a small sizing helper.
package wb_queue_pkg;

  localparam int WB_WIDTH   = 32;
  localparam int WB_REGBITS = 5;
  localparam int WB_DEPTH   = 4;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Write-back queue bus: producer handshake, register-file drain port,
// operand forwarding lookups and occupancy.
interface wb_queue_if
  import wb_queue_pkg::*;
#(
  parameter int WIDTH   = WB_WIDTH,
  parameter int REGBITS = WB_REGBITS,
  parameter int DEPTH   = WB_DEPTH
);

  logic                       in_valid;
  logic                       in_ready;
  logic [REGBITS-1:0]         in_wa;
  logic [WIDTH-1:0]           in_wd;
  logic                       stall;
  logic                       regwrite;
  logic [REGBITS-1:0]         wa;
  logic [WIDTH-1:0]           wd;
  logic [REGBITS-1:0]         ra1;
  logic [REGBITS-1:0]         ra2;
  logic                       fwd1_hit;
  logic                       fwd2_hit;
  logic [WIDTH-1:0]           fwd1_data;
  logic [WIDTH-1:0]           fwd2_data;
  logic [cnt_bits(DEPTH)-1:0] count;

  modport slave (
    input  in_valid, in_wa, in_wd, stall, ra1, ra2,
    output in_ready, regwrite, wa, wd,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
  );

  modport master (
    output in_valid, in_wa, in_wd, stall, ra1, ra2,
    input  in_ready, regwrite, wa, wd,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
  );

endinterface

// File: rtl/wb_fwd_sel.sv
// Youngest-match forwarding selector for one read port.
// Entries arrive ordered oldest (index 0) to youngest (index DEPTH-1).
module wb_fwd_sel
  import wb_queue_pkg::*;
#(
  parameter int WIDTH   = WB_WIDTH,
  parameter int REGBITS = WB_REGBITS,
  parameter int DEPTH   = WB_DEPTH
) (
  input  logic [REGBITS-1:0]            ra_i,
  input  logic [DEPTH-1:0]              valid_i,
  input  logic [DEPTH-1:0][REGBITS-1:0] wa_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]   wd_i,
  output logic                          hit_o,
  output logic [WIDTH-1:0]              data_o
);

  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_i[gi] && (wa_i[gi] == ra_i) && (ra_i != '0);
    end
  endgenerate

  // Scanning oldest to youngest lets the last match win.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        hit_o  = 1'b1;
        data_o = wd_i[k];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Register-file write-back queue: FIFO of pending writes drained when not
// stalled, with youngest-entry forwarding to two operand read ports.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int WIDTH   = WB_WIDTH,
  parameter int REGBITS = WB_REGBITS,
  parameter int DEPTH   = WB_DEPTH
) (
  input  logic    clk,
  input  logic    rst_n,
  wb_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_bits(DEPTH);

  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic [REGBITS-1:0] mem_wa [DEPTH];
  logic [WIDTH-1:0]   mem_wd [DEPTH];

  logic               empty;
  logic               ready;
  logic               accept;
  logic               push;
  logic               pop;

  always_comb begin
    empty  = (count_q == '0);
    ready  = (count_q < CW'(DEPTH));
    accept = bus.in_valid && ready;
    // Writes to r0 complete the handshake but never occupy a slot.
    push   = accept && (bus.in_wa != '0);
    pop    = !empty && !bus.stall;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never cleared; validity comes from count/pointers only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa[wr_ptr_q] <= bus.in_wa;
      mem_wd[wr_ptr_q] <= bus.in_wd;
    end
  end

  // Re-order the ring into age order (slot 0 = head) for the selectors.
  logic [PW-1:0]                ord_idx [DEPTH];
  logic [DEPTH-1:0]             ord_valid;
  logic [DEPTH-1:0][REGBITS-1:0] ord_wa;
  logic [DEPTH-1:0][WIDTH-1:0]   ord_wd;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_order
      assign ord_idx[gi]   = rd_ptr_q + PW'(gi);
      assign ord_valid[gi] = (CW'(gi) < count_q);
      assign ord_wa[gi]    = mem_wa[ord_idx[gi]];
      assign ord_wd[gi]    = mem_wd[ord_idx[gi]];
    end
  endgenerate

  assign bus.in_ready = ready;
  assign bus.regwrite = pop;
  assign bus.wa       = empty ? '0 : mem_wa[rd_ptr_q];
  assign bus.wd       = empty ? '0 : mem_wd[rd_ptr_q];
  assign bus.count    = count_q;

  wb_fwd_sel #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS),
    .DEPTH   (DEPTH)
  ) u_fwd1 (
    .ra_i    (bus.ra1),
    .valid_i (ord_valid),
    .wa_i    (ord_wa),
    .wd_i    (ord_wd),
    .hit_o   (bus.fwd1_hit),
    .data_o  (bus.fwd1_data)
  );

  wb_fwd_sel #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS),
    .DEPTH   (DEPTH)
  ) u_fwd2 (
    .ra_i    (bus.ra2),
    .valid_i (ord_valid),
    .wa_i    (ord_wa),
    .wd_i    (ord_wd),
    .hit_o   (bus.fwd2_hit),
    .data_o  (bus.fwd2_data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: handshake, drain order, full back-pressure,
// forwarding, r0 writes and asynchronous reset.
module tb_wb_queue;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  wb_queue_if #(.WIDTH(32), .REGBITS(5), .DEPTH(4)) bus ();

  wb_queue #(.WIDTH(32), .REGBITS(5), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_wa     = '0;
    bus.in_wd     = '0;
    bus.stall     = 1'b0;
    bus.ra1       = 5'd3;
    bus.ra2       = 5'd0;

    // Reset state
    #3;
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_regwrite", 32'(bus.regwrite), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wa",       32'(bus.wa),       32'd0);
    chk("rst_wd",       bus.wd,            32'd0);
    chk("rst_fwd1_hit", 32'(bus.fwd1_hit), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // Single write, minimum latency
    bus.in_valid = 1'b1; bus.in_wa = 5'd3; bus.in_wd = 32'h11;
    #1;
    chk("offer_not_fwd", 32'(bus.fwd1_hit), 32'd0);
    chk("idle_ready",    32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("lat_regwrite", 32'(bus.regwrite), 32'd1);
    chk("lat_wa",       32'(bus.wa),       32'd3);
    chk("lat_wd",       bus.wd,            32'h11);
    chk("lat_count",    32'(bus.count),    32'd1);
    chk("lat_fwd1_hit", 32'(bus.fwd1_hit), 32'd1);
    chk("lat_fwd1_dat", bus.fwd1_data,     32'h11);
    tick();
    chk("drained_count", 32'(bus.count),    32'd0);
    chk("drained_rw",    32'(bus.regwrite), 32'd0);
    chk("drained_wa",    32'(bus.wa),       32'd0);

    // Fill under stall
    bus.stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.in_wa = 5'(i); bus.in_wd = 32'h100 + 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("full_count",    32'(bus.count),    32'd4);
    chk("full_ready",    32'(bus.in_ready), 32'd0);
    chk("full_stall_rw", 32'(bus.regwrite), 32'd0);
    bus.ra1 = 5'd2; bus.ra2 = 5'd6;
    bus.in_valid = 1'b1; bus.in_wa = 5'd6; bus.in_wd = 32'h106;
    #1;
    chk("full_fwd1_hit", 32'(bus.fwd1_hit), 32'd1);
    chk("full_fwd1_dat", bus.fwd1_data,     32'h102);
    chk("held_no_fwd",   32'(bus.fwd2_hit), 32'd0);
    tick();
    chk("held_count", 32'(bus.count), 32'd4);

    // Release stall while full with an offer pending
    bus.stall = 1'b0;
    #1;
    chk("d1_regwrite", 32'(bus.regwrite), 32'd1);
    chk("d1_wa",       32'(bus.wa),       32'd1);
    chk("d1_wd",       bus.wd,            32'h101);
    chk("d1_ready",    32'(bus.in_ready), 32'd0);
    tick();
    chk("d2_count", 32'(bus.count),    32'd3);
    chk("d2_wa",    32'(bus.wa),       32'd2);
    chk("d2_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("d3_count", 32'(bus.count), 32'd3);
    chk("d3_wa",    32'(bus.wa),    32'd3);
    tick();
    chk("d4_count", 32'(bus.count), 32'd2);
    chk("d4_wa",    32'(bus.wa),    32'd4);
    tick();
    chk("d5_count",    32'(bus.count),    32'd1);
    chk("d5_wa",       32'(bus.wa),       32'd6);
    chk("d5_wd",       bus.wd,            32'h106);
    chk("d5_fwd2_hit", 32'(bus.fwd2_hit), 32'd1);
    chk("d5_fwd2_dat", bus.fwd2_data,     32'h106);
    tick();
    chk("d6_count",    32'(bus.count),    32'd0);
    chk("d6_regwrite", 32'(bus.regwrite), 32'd0);

    // Youngest-match forwarding
    bus.stall = 1'b1; bus.ra1 = 5'd5; bus.ra2 = 5'd0;
    bus.in_valid = 1'b1; bus.in_wa = 5'd5; bus.in_wd = 32'hA;
    tick();
    bus.in_wd = 32'hB;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("yf_count",    32'(bus.count),    32'd2);
    chk("yf_fwd1_hit", 32'(bus.fwd1_hit), 32'd1);
    chk("yf_fwd1_dat", bus.fwd1_data,     32'hB);
    chk("yf_fwd2_hit", 32'(bus.fwd2_hit), 32'd0);
    chk("yf_fwd2_dat", bus.fwd2_data,     32'd0);
    bus.stall = 1'b0;
    #1;
    chk("yf_pop_rw",   32'(bus.regwrite), 32'd1);
    chk("yf_pop_wd",   bus.wd,            32'hA);
    chk("yf_pop_fwd1", bus.fwd1_data,     32'hB);
    tick();
    chk("yf2_wa",   32'(bus.wa),   32'd5);
    chk("yf2_wd",   bus.wd,        32'hB);
    chk("yf2_fwd1", bus.fwd1_data, 32'hB);
    tick();
    chk("yf3_count",    32'(bus.count),    32'd0);
    chk("yf3_fwd1_hit", 32'(bus.fwd1_hit), 32'd0);
    chk("yf3_fwd1_dat", bus.fwd1_data,     32'd0);

    // Write to r0 is consumed without an entry
    bus.in_valid = 1'b1; bus.in_wa = 5'd0; bus.in_wd = 32'hFFFF;
    #1;
    chk("r0_ready_pre", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("r0_count", 32'(bus.count),    32'd0);
    chk("r0_rw",    32'(bus.regwrite), 32'd0);
    chk("r0_ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset with pending entries
    bus.stall = 1'b1; bus.ra1 = 5'd8;
    for (int i = 7; i <= 9; i++) begin
      bus.in_valid = 1'b1; bus.in_wa = 5'(i); bus.in_wd = 32'h200 + 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_count", 32'(bus.count),    32'd3);
    chk("pre_rst_fwd1",  32'(bus.fwd1_hit), 32'd1);
    bus.stall = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count),    32'd0);
    chk("arst_rw",    32'(bus.regwrite), 32'd0);
    chk("arst_wa",    32'(bus.wa),       32'd0);
    chk("arst_fwd1",  32'(bus.fwd1_hit), 32'd0);
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_rw",    32'(bus.regwrite), 32'd0);
      chk("post_rst_count", 32'(bus.count),    32'd0);
    end

    // Pointers restart from zero after reset
    bus.in_valid = 1'b1; bus.in_wa = 5'd10; bus.in_wd = 32'h55;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("after_rst_rw", 32'(bus.regwrite), 32'd1);
    chk("after_rst_wa", 32'(bus.wa),       32'd10);
    chk("after_rst_wd", bus.wd,            32'h55);
    tick();
    chk("after_rst_empty", 32'(bus.count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
